// File: rtl/cordic_pkg.sv
// Shared state type, watchdog sizing and reload helper for the CORDIC magnitude/phase feeder.
package cordic_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam int WDOG_W = 8;

  function automatic int tmo_load(input int n, input int tmo_margin);
    return n + 2 + tmo_margin;
  endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// Single-clock FIFO with registered occupancy; push when full and pop when empty are ignored.
module cordic_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign dout    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/cordic_mag_ph_feeder.sv
// Buffers x/y samples and issues them one at a time to the serial CORDIC core,
// with a per-operation watchdog and a saturating drop counter.
module cordic_mag_ph_feeder
  import cordic_pkg::*;
#(
  parameter int N          = 13,
  parameter int XY_WIDTH   = 18,
  parameter int DEPTH      = 8,
  parameter int TMO_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_vld,
  input  logic [XY_WIDTH-1:0]        xin,
  input  logic [XY_WIDTH-1:0]        yin,
  output logic                       in_rdy,
  output logic                       st,
  output logic [XY_WIDTH-1:0]        xout,
  output logic [XY_WIDTH-1:0]        yout,
  input  logic                       core_rdy,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_cnt,
  output logic                       tmo_err,
  input  logic                       clr
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [WDOG_W-1:0] WDOG_INIT = WDOG_W'(tmo_load(N, TMO_MARGIN));

  state_t                  state;
  state_t                  state_d;
  logic [WDOG_W-1:0]       wdog;
  logic [WDOG_W-1:0]       wdog_d;
  logic [2*XY_WIDTH-1:0]   head;
  logic [XY_WIDTH-1:0]     x_q;
  logic [XY_WIDTH-1:0]     y_q;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic                    timeout;

  assign in_rdy = (level != LW'(DEPTH));
  assign push   = in_vld && in_rdy;
  assign drop   = in_vld && !in_rdy;
  assign busy   = (state == BUSY);

  cordic_sync_fifo #(
    .WIDTH (2*XY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({xin, yin}),
    .dout  (head),
    .level (level)
  );

  // Operands are presented straight from the FIFO head during st, then held from the registered copy.
  assign xout = st ? head[2*XY_WIDTH-1:XY_WIDTH] : x_q;
  assign yout = st ? head[XY_WIDTH-1:0]          : y_q;

  always_comb begin
    state_d = state;
    wdog_d  = wdog;
    pop     = 1'b0;
    st      = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop     = 1'b1;
          st      = 1'b1;
          wdog_d  = WDOG_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (core_rdy) begin
          state_d = IDLE;
        end else if (wdog <= WDOG_W'(1)) begin
          timeout = 1'b1;
          wdog_d  = '0;
          state_d = IDLE;
        end else begin
          wdog_d = wdog - WDOG_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A timeout beats a concurrent clear; a drop during clear leaves a count of one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wdog     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      drop_cnt <= '0;
      tmo_err  <= 1'b0;
    end else begin
      state <= state_d;
      wdog  <= wdog_d;
      if (pop) begin
        x_q <= head[2*XY_WIDTH-1:XY_WIDTH];
        y_q <= head[XY_WIDTH-1:0];
      end
      if (clr)
        drop_cnt <= drop ? 16'd1 : 16'd0;
      else if (drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      if (timeout)
        tmo_err <= 1'b1;
      else if (clr)
        tmo_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_mag_ph_feeder.sv
// Directed bench for cordic_mag_ph_feeder: accepted samples go into a scoreboard queue,
// a monitor pops and compares on every st, and a small core model answers with core_rdy.
`timescale 1ns/1ps
module tb_cordic_mag_ph_feeder;

  localparam int N     = 13;
  localparam int XW    = 18;
  localparam int DEPTH = 8;
  localparam int TMO   = 4;
  localparam int LAT   = N + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_vld = 1'b0;
  logic          core_rdy = 1'b0;
  logic          clr = 1'b0;
  logic [XW-1:0] xin = '0;
  logic [XW-1:0] yin = '0;
  logic [XW-1:0] xout;
  logic [XW-1:0] yout;
  logic          in_rdy;
  logic          st;
  logic          busy;
  logic          tmo_err;
  logic [3:0]    level;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int drops_exp = 0;
  int max_level = 0;
  int core_lat = LAT;
  bit core_silent = 1'b0;
  bit saw_not_rdy = 1'b0;
  logic [2*XW-1:0] sb [$];
  int st_cycles [$];
  logic [2*XW-1:0] exp_op;
  logic [XW-1:0] last_x = '0;
  logic [XW-1:0] last_y = '0;
  logic st_prev = 1'b0;

  cordic_mag_ph_feeder #(
    .N          (N),
    .XY_WIDTH   (XW),
    .DEPTH      (DEPTH),
    .TMO_MARGIN (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (in_vld),
    .xin      (xin),
    .yin      (yin),
    .in_rdy   (in_rdy),
    .st       (st),
    .xout     (xout),
    .yout     (yout),
    .core_rdy (core_rdy),
    .busy     (busy),
    .level    (level),
    .drop_cnt (drop_cnt),
    .tmo_err  (tmo_err),
    .clr      (clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, want, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [XW-1:0] x, input logic [XW-1:0] y);
    @(posedge clk);
    #1;
    in_vld = 1'b1;
    xin    = x;
    yin    = y;
    @(negedge clk);
    acc_cyc = cyc;
    if (in_rdy) sb.push_back({x, y});
    else drops_exp++;
  endtask

  task automatic idleInput();
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  task automatic gotoNeg(input int k);
    do @(negedge clk); while (cyc < k);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || level != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_budget", int'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  // Core model: answers each st with a one-cycle core_rdy core_lat cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (st && !core_silent) begin
        repeat (core_lat) @(posedge clk);
        #1 core_rdy = 1'b1;
        @(posedge clk);
        #1 core_rdy = 1'b0;
      end
    end
  end

  // Monitor: operand order, st width, operand hold and occupancy bound.
  always @(negedge clk) begin
    if (!reset) begin
      last_x  = '0;
      last_y  = '0;
      st_prev = 1'b0;
    end else begin
      if (st) begin
        st_cycles.push_back(cyc);
        checkOutput("st_one_cycle", int'(st_prev), 0);
        checkOutput("sb_nonempty_at_st", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_op = sb.pop_front();
          checkOutput("xout", int'(xout), int'(exp_op[2*XW-1:XW]));
          checkOutput("yout", int'(yout), int'(exp_op[XW-1:0]));
        end
        last_x = xout;
        last_y = yout;
      end else begin
        checkOutput("xout_hold", int'(xout), int'(last_x));
        checkOutput("yout_hold", int'(yout), int'(last_y));
      end
      st_prev = st;
      checkOutput("level_le_depth", int'(level <= DEPTH), 1);
      if (int'(level) > max_level) max_level = int'(level);
      if (!in_rdy) saw_not_rdy = 1'b1;
    end
  end

  initial begin
    #600000;
    errors++;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int t;
    int d;
    int gap;

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    checkOutput("rst_st", int'(st), 0);
    checkOutput("rst_xout", int'(xout), 0);
    checkOutput("rst_yout", int'(yout), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_drop_cnt", int'(drop_cnt), 0);
    checkOutput("rst_tmo_err", int'(tmo_err), 0);
    checkOutput("rst_in_rdy", int'(in_rdy), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);

    // Single sample latency
    applyStimulus(18'h10000, 18'h3F000);
    t = acc_cyc;
    checkOutput("t1_level_at_accept", int'(level), 0);
    idleInput();
    gotoNeg(t + 1);
    checkOutput("t1_st", int'(st), 1);
    checkOutput("t1_xout", int'(xout), 'h10000);
    checkOutput("t1_yout", int'(yout), 'h3F000);
    checkOutput("t1_level_c1", int'(level), 1);
    checkOutput("t1_busy_c1", int'(busy), 0);
    gotoNeg(t + 2);
    checkOutput("t1_st_c2", int'(st), 0);
    checkOutput("t1_busy_c2", int'(busy), 1);
    checkOutput("t1_level_c2", int'(level), 0);
    gotoNeg(t + 16);
    checkOutput("t1_core_rdy", int'(core_rdy), 1);
    checkOutput("t1_busy_at_rdy", int'(busy), 1);
    gotoNeg(t + 17);
    checkOutput("t1_busy_after", int'(busy), 0);
    waitDrain(50);

    // Burst of 8 back-to-back samples
    st_cycles.delete();
    max_level   = 0;
    saw_not_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(18'(i * 4096 + 'h123), 18'(18'h3FFFF - i * 17));
      if (i == 0) t = acc_cyc;
    end
    idleInput();
    waitDrain(400);
    checkOutput("burst_st_count", st_cycles.size(), 8);
    if (st_cycles.size() == 8) begin
      checkOutput("burst_first_st", st_cycles[0] - t, 1);
      for (int i = 1; i < 8; i++)
        checkOutput("burst_st_spacing", st_cycles[i] - st_cycles[i-1], N + 3);
    end
    checkOutput("burst_level_peak", max_level, 7);
    checkOutput("burst_in_rdy_stayed", int'(saw_not_rdy), 0);

    // Timeout, then timeout coinciding with clr, then plain clr
    core_silent = 1'b1;
    applyStimulus(18'h00ABC, 18'h01DEF);
    t = acc_cyc;
    applyStimulus(18'h2AAAA, 18'h15555);
    idleInput();
    gotoNeg(t + 20);
    checkOutput("tmo_busy_last", int'(busy), 1);
    checkOutput("tmo_err_before", int'(tmo_err), 0);
    gotoNeg(t + 21);
    checkOutput("tmo_err_set", int'(tmo_err), 1);
    checkOutput("tmo_busy_cleared", int'(busy), 0);
    checkOutput("tmo_next_st", int'(st), 1);
    gotoNeg(t + 39);
    @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    checkOutput("tmo2_busy_at_clr", int'(busy), 1);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    checkOutput("tmo_wins_over_clr", int'(tmo_err), 1);
    checkOutput("tmo2_busy_after", int'(busy), 0);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_tmo_err", int'(tmo_err), 0);
    core_silent = 1'b0;
    waitDrain(100);

    // Overflow: 12 back-to-back samples, then a drop coinciding with clr
    max_level   = 0;
    saw_not_rdy = 1'b0;
    drops_exp   = 0;
    for (int i = 0; i < 12; i++)
      applyStimulus(18'(i * 3 + 'h100), 18'(i * 5 + 'h200));
    @(posedge clk);
    #1;
    clr = 1'b1;
    xin = 18'h3FFFF;
    yin = 18'h3FFFF;
    @(negedge clk);
    checkOutput("ovf_drop_cnt", int'(drop_cnt), 3);
    checkOutput("ovf_in_rdy", int'(in_rdy), 0);
    checkOutput("ovf_level_full", int'(level), 8);
    @(posedge clk);
    #1;
    clr    = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    checkOutput("clr_with_drop", int'(drop_cnt), 1);
    checkOutput("ovf_model_drops", drops_exp, 3);
    checkOutput("ovf_level_peak", max_level, 8);
    checkOutput("ovf_saw_not_rdy", int'(saw_not_rdy), 1);
    waitDrain(400);

    // Reset in the middle of a burst
    for (int i = 0; i < 6; i++) begin
      applyStimulus(18'(i + 'h3000), 18'(i + 'h1000));
      if (i == 0) t = acc_cyc;
    end
    @(posedge clk);
    #1 in_vld = 1'b0;
    checkOutput("mid_level_before", int'(level), 5);
    checkOutput("mid_busy_before", int'(busy), 1);
    reset = 1'b0;
    sb.delete();
    #1;
    checkOutput("mid_rst_st", int'(st), 0);
    checkOutput("mid_rst_xout", int'(xout), 0);
    checkOutput("mid_rst_yout", int'(yout), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_level", int'(level), 0);
    checkOutput("mid_rst_drop_cnt", int'(drop_cnt), 0);
    checkOutput("mid_rst_tmo_err", int'(tmo_err), 0);
    checkOutput("mid_rst_in_rdy", int'(in_rdy), 1);
    gotoNeg(t + 9);
    @(posedge clk);
    #1 reset = 1'b1;
    gotoNeg(t + 16);
    checkOutput("late_core_rdy_seen", int'(core_rdy), 1);
    checkOutput("late_core_rdy_no_st", int'(st), 0);
    gotoNeg(t + 17);
    checkOutput("late_core_rdy_idle", int'(busy), 0);
    checkOutput("late_core_rdy_no_st2", int'(st), 0);
    applyStimulus(18'h0F0F0, 18'h30303);
    d = acc_cyc;
    idleInput();
    gotoNeg(d + 1);
    checkOutput("post_rst_st", int'(st), 1);
    checkOutput("post_rst_level", int'(level), 1);
    waitDrain(50);

    // Pointer wrap with random gaps
    st_cycles.delete();
    drops_exp = 0;
    max_level = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(18'(i * 5003 + 11), 18'(i * 911 + 3));
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        idleInput();
        repeat (gap - 1) @(posedge clk);
      end
    end
    idleInput();
    waitDrain(1200);
    checkOutput("wrap_st_count", st_cycles.size(), 40 - drops_exp);
    checkOutput("wrap_drop_cnt", int'(drop_cnt), drops_exp);
    checkOutput("wrap_level_bound", int'(max_level <= DEPTH), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
